// File: rtl/audio_pkg.sv
// Shared audio pipeline constants and the IFFT output buffer state type.
package audio_pkg;

   localparam int SIZE       = 16;
   localparam int INPUT_SIZE = 512;
   localparam int SAMPLES    = 2048;

   localparam int WORDS  = SAMPLES * SIZE / INPUT_SIZE;
   localparam int LANES  = INPUT_SIZE / SIZE;
   localparam int CNT_W  = $clog2(SAMPLES);
   localparam int IDX_W  = $clog2(WORDS);
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } out_state_t;

endpackage

// File: rtl/out_sample_scale.sv
// Combinational round-half-up, 1/N arithmetic shift and reduction of one IFFT
// real sample to SIZE bits. With IFFT_OUT_SATURATE_EN defined the result is
// clamped and sat flags the clamp; otherwise it wraps and sat stays low.
module out_sample_scale
   import audio_pkg::*;
#(
   parameter int IN_WIDTH    = 28,
   parameter int SCALE_SHIFT = 11
) (
   input  logic signed [IN_WIDTH-1:0] in_real,
   output logic signed [SIZE-1:0]     sample_out,
   output logic                       sat
);

   // One extra bit of headroom so adding the half-LSB can never overflow.
   localparam logic signed [IN_WIDTH:0] HALF =
      {{(IN_WIDTH-SCALE_SHIFT+1){1'b0}}, 1'b1, {(SCALE_SHIFT-1){1'b0}}};

   logic signed [IN_WIDTH:0] r_p0;

   function automatic logic signed [IN_WIDTH:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
      logic signed [IN_WIDTH:0] ext;
      ext = {x[IN_WIDTH-1], x};
      return (ext + HALF) >>> SCALE_SHIFT;
   endfunction

   assign r_p0 = round_shift(in_real);

`ifdef IFFT_OUT_SATURATE_EN
   localparam logic signed [IN_WIDTH:0] MAX_V = (IN_WIDTH+1)'((2**(SIZE-1)) - 1);
   localparam logic signed [IN_WIDTH:0] MIN_V = (IN_WIDTH+1)'(-(2**(SIZE-1)));

   function automatic logic clipped(input logic signed [IN_WIDTH:0] r);
      return (r > MAX_V) || (r < MIN_V);
   endfunction

   function automatic logic signed [SIZE-1:0] saturate(input logic signed [IN_WIDTH:0] r);
      if (r > MAX_V)
         return {1'b0, {(SIZE-1){1'b1}}};
      else if (r < MIN_V)
         return {1'b1, {(SIZE-1){1'b0}}};
      else
         return r[SIZE-1:0];
   endfunction

   // Clamp the shifted sample into the SIZE-bit signed range.
   always_comb begin
      sample_out = saturate(r_p0);
      sat        = clipped(r_p0);
   end
`else
   logic unused_hi;
   assign unused_hi = ^r_p0[IN_WIDTH:SIZE];

   // Keep only the low SIZE bits; out-of-range values wrap.
   always_comb begin
      sample_out = r_p0[SIZE-1:0];
      sat        = 1'b0;
   end
`endif

endmodule

// File: rtl/ifft_output_buffer.sv
// IFFT output buffer: captures one 2048-sample frame of the IFFT real stream,
// scales each sample to 16 bits, packs 32 samples per 512-bit word into a
// 64-word RAM and lets the CPU read words back by index.
// Optional build macro IFFT_OUT_SATURATE_EN selects saturating scaling with a
// sticky overflow flag; without it samples wrap and overflow reads 0.
module ifft_output_buffer
   import audio_pkg::*;
#(
   parameter int IN_WIDTH    = 28,
   parameter int SCALE_SHIFT = 11
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       in_valid,
   input  logic                       in_sync,
   input  logic signed [IN_WIDTH-1:0] in_real,
   input  logic [IDX_W-1:0]           rd_index,
   output logic [INPUT_SIZE-1:0]      data_out,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow
);

   localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(SAMPLES - 1);
   localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);

   out_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic ovf, ovf_nxt;

   logic                  vld_p0;
   logic signed [SIZE-1:0] sample_p0;
   logic                  sat_p0;
   logic [LANE_W-1:0]     lane_p0;
   logic [IDX_W-1:0]      wr_idx_p0;
   logic                  wr_p0;
   logic [INPUT_SIZE-1:0] word_p0;
   logic [INPUT_SIZE-1:0] stage_q;

   logic [INPUT_SIZE-1:0] ram [WORDS];

   out_sample_scale #(
      .IN_WIDTH    (IN_WIDTH),
      .SCALE_SHIFT (SCALE_SHIFT)
   ) u_scale (
      .in_real    (in_real),
      .sample_out (sample_p0),
      .sat        (sat_p0)
   );

   assign lane_p0   = cnt[LANE_W-1:0];
   assign wr_idx_p0 = cnt[CNT_W-1:LANE_W];
   assign wr_p0     = vld_p0 && (lane_p0 == LAST_LANE);

   // Next state, sample acceptance and counter/overflow update; start wins over a sample.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      vld_p0    = 1'b0;
      if (start) begin
         state_nxt = ARMED;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state)
            ARMED: begin
               if (in_valid && in_sync) begin
                  vld_p0    = 1'b1;
                  state_nxt = CAPTURE;
               end
            end
            CAPTURE: begin
               if (in_valid) begin
                  vld_p0 = 1'b1;
                  if (cnt == LAST_SAMPLE)
                     state_nxt = DONE;
               end
            end
            default: ;
         endcase
         if (vld_p0) begin
            cnt_nxt = cnt + 1'b1;
            if (sat_p0)
               ovf_nxt = 1'b1;
         end
      end
   end

   // Control registers: state, sample counter, sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

   // Merge the accepted sample into its lane of the word being assembled.
   always_comb begin
      word_p0 = stage_q;
      word_p0[SIZE*lane_p0 +: SIZE] = sample_p0;
   end

   // Staging word fills lane by lane; stale lanes are always overwritten before a write.
   always_ff @(posedge clk) begin
      if (vld_p0)
         stage_q <= word_p0;
   end

   // Commit the completed word, including the lane accepted this cycle.
   always_ff @(posedge clk) begin
      if (wr_p0)
         ram[wr_idx_p0] <= word_p0;
   end

   // Registered read port; sees the old contents when reading the word being written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_out <= '0;
      else
         data_out <= ram[rd_index];
   end

   assign busy     = (state == ARMED) || (state == CAPTURE);
   assign done     = (state == DONE);
   assign overflow = ovf;

endmodule
